// File: rtl/gf_pipe_adder.sv
// gf_pipe_adder
//   Pipelined dual-mode adder. Each transaction carries a mode tag:
//   binary (carry-propagate add with carry-in) or GF(2^m) (carry-free XOR).
//   The carry chain is cut into STAGES chunks of CHUNK bits. Stage k adds
//   chunk k and registers it together with the carry into chunk k+1.
//   Operand chunks that have not been added yet travel down the pipe next to
//   the finished sum chunks, so every transaction leaves as one aligned word.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_gf, in_cin       mode tag (1 = XOR), carry-in (binary mode only)
//   in_a, in_b          operands, WIDTH bits
//   out_valid/out_ready output handshake
//   out_sum, out_cout   result and carry-out (carry-out is 0 in GF mode)
//   out_gf              mode tag of the result
module gf_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_gf,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_gf
);

    localparam int CHUNK = (STAGES > 0) ? (WIDTH / STAGES) : 1;

    generate
        if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("gf_pipe_adder: STAGES must be >= 1 and divide WIDTH");
        end
    endgenerate

    // Pipeline registers, indexed [stage][chunk]. Stage k keeps finished sum
    // chunks 0..k and the still-pending operand chunks k+1..STAGES-1.
    logic [CHUNK-1:0]  a_skew_reg   [STAGES][STAGES];
    logic [CHUNK-1:0]  b_skew_reg   [STAGES][STAGES];
    logic [CHUNK-1:0]  sum_skew_reg [STAGES][STAGES];
    logic [STAGES-1:0] vld_reg;
    logic [STAGES-1:0] gf_reg;
    logic [STAGES-1:0] cy_reg;

    // Values feeding each stage: the input port for stage 0, otherwise the
    // registers of the previous stage.
    logic [CHUNK-1:0]  a_src   [STAGES][STAGES];
    logic [CHUNK-1:0]  b_src   [STAGES][STAGES];
    logic [CHUNK-1:0]  sum_src [STAGES][STAGES];
    logic [STAGES-1:0] vld_src;
    logic [STAGES-1:0] gf_src;
    logic [STAGES-1:0] cy_src;

    logic [CHUNK-1:0]  sum_next [STAGES];
    logic [STAGES-1:0] cy_next;

    logic adv;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign adv      = ~vld_reg[STAGES-1] | out_ready;
    assign in_ready = adv;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [CHUNK:0] bin_sum;

            for (genvar gj = 0; gj < STAGES; gj++) begin : g_chunk
                if (gi == 0) begin : g_first
                    assign a_src[gi][gj]   = in_a[gj*CHUNK +: CHUNK];
                    assign b_src[gi][gj]   = in_b[gj*CHUNK +: CHUNK];
                    assign sum_src[gi][gj] = '0;
                end else begin : g_next
                    assign a_src[gi][gj]   = a_skew_reg[gi-1][gj];
                    assign b_src[gi][gj]   = b_skew_reg[gi-1][gj];
                    assign sum_src[gi][gj] = sum_skew_reg[gi-1][gj];
                end
            end

            if (gi == 0) begin : g_ctl_first
                assign vld_src[gi] = in_valid;
                assign gf_src[gi]  = in_gf;
                assign cy_src[gi]  = in_cin & ~in_gf;
            end else begin : g_ctl_next
                assign vld_src[gi] = vld_reg[gi-1];
                assign gf_src[gi]  = gf_reg[gi-1];
                assign cy_src[gi]  = cy_reg[gi-1] & ~gf_reg[gi-1];
            end

            // Both modes share the chunk adder; GF mode takes the XOR and
            // kills the outgoing carry so nothing leaks into the next chunk.
            assign bin_sum = {1'b0, a_src[gi][gi]} + {1'b0, b_src[gi][gi]}
                           + {{CHUNK{1'b0}}, cy_src[gi]};
            assign sum_next[gi] = gf_src[gi] ? (a_src[gi][gi] ^ b_src[gi][gi])
                                             : bin_sum[CHUNK-1:0];
            assign cy_next[gi]  = bin_sum[CHUNK] & ~gf_src[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg <= '0;
            gf_reg  <= '0;
            cy_reg  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < STAGES; j++) begin
                    a_skew_reg[k][j]   <= '0;
                    b_skew_reg[k][j]   <= '0;
                    sum_skew_reg[k][j] <= '0;
                end
            end
        end else if (adv) begin
            vld_reg <= vld_src;
            gf_reg  <= gf_src;
            cy_reg  <= cy_next;
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < STAGES; j++) begin
                    if (j < k) begin
                        sum_skew_reg[k][j] <= sum_src[k][j];
                    end else if (j == k) begin
                        sum_skew_reg[k][j] <= sum_next[k];
                    end else begin
                        sum_skew_reg[k][j] <= '0;
                    end
                    if (j > k) begin
                        a_skew_reg[k][j] <= a_src[k][j];
                        b_skew_reg[k][j] <= b_src[k][j];
                    end else begin
                        a_skew_reg[k][j] <= '0;
                        b_skew_reg[k][j] <= '0;
                    end
                end
            end
        end
    end

    assign out_valid = vld_reg[STAGES-1];
    assign out_gf    = gf_reg[STAGES-1];
    assign out_cout  = cy_reg[STAGES-1] & ~gf_reg[STAGES-1];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_out
            assign out_sum[gi*CHUNK +: CHUNK] = sum_skew_reg[STAGES-1][gi];
        end
    endgenerate

endmodule

// File: tb/tb_gf_pipe_adder.sv
// tb_gf_pipe_adder
//   Three instances: 32/4, 8/1 and 16/16. A per-instance reference queue
//   holds the arithmetic result of every accepted operand pair, and one
//   compare process per instance checks every output transfer, the ready
//   rule, output stability under backpressure, reset values and latency.
//   Directed vectors additionally carry hand-computed literal results.
module tb_gf_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  drv_valid, drv_gf, drv_cin, drv_ordy, dut_irdy, drv_lit, drv_lit_cout;
    logic [31:0] drv_a [3];
    logic [31:0] drv_b [3];
    logic [31:0] drv_lit_sum [3];
    int          pend [3];
    bit          rand_done;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        gf;
        logic        lit;
        logic [31:0] lit_sum;
        logic        lit_cout;
        int          acc_cyc;
        int          acc_stall;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 32 : (gi == 1) ? 8 : 16;
            localparam int S = (gi == 0) ? 4 : (gi == 1) ? 1 : 16;
            localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

            logic [W-1:0] out_sum;
            logic         out_valid, out_cout, out_gf, in_ready;

            gf_pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (drv_valid[gi]),
                .in_ready  (in_ready),
                .in_gf     (drv_gf[gi]),
                .in_cin    (drv_cin[gi]),
                .in_a      (drv_a[gi][W-1:0]),
                .in_b      (drv_b[gi][W-1:0]),
                .out_valid (out_valid),
                .out_ready (drv_ordy[gi]),
                .out_sum   (out_sum),
                .out_cout  (out_cout),
                .out_gf    (out_gf)
            );
            assign dut_irdy[gi] = in_ready;

            exp_t         exp_q [$];
            exp_t         e;
            int           cyc = 0;
            int           stalls = 0;
            bit           was_rst = 1'b0;
            bit           hold_v = 1'b0;
            logic [W-1:0] hold_sum;
            logic         hold_cout, hold_gf;
            logic [63:0]  ma, mb, full;

            always @(negedge clk) begin
                if (rst) begin
                    exp_q.delete();
                    was_rst = 1'b1;
                    hold_v  = 1'b0;
                end else begin
                    if (was_rst) begin
                        chk($sformatf("i%0d reset out_valid", gi), 64'(out_valid), 64'd0);
                        chk($sformatf("i%0d reset out_sum", gi), 64'(out_sum), 64'd0);
                        chk($sformatf("i%0d reset out_cout", gi), 64'(out_cout), 64'd0);
                        chk($sformatf("i%0d reset out_gf", gi), 64'(out_gf), 64'd0);
                        chk($sformatf("i%0d reset in_ready", gi), 64'(in_ready), 64'd1);
                        was_rst = 1'b0;
                    end
                    chk($sformatf("i%0d in_ready", gi), 64'(in_ready),
                        64'(!out_valid || drv_ordy[gi]));
                    if (hold_v) begin
                        chk($sformatf("i%0d hold valid", gi), 64'(out_valid), 64'd1);
                        chk($sformatf("i%0d hold sum", gi), 64'(out_sum), 64'(hold_sum));
                        chk($sformatf("i%0d hold cout", gi), 64'(out_cout), 64'(hold_cout));
                        chk($sformatf("i%0d hold gf", gi), 64'(out_gf), 64'(hold_gf));
                    end
                    if (out_valid && drv_ordy[gi]) begin
                        $display("i%0d t=%0d gf=%0d sum=%0h cout=%0d", gi, cyc, out_gf, out_sum, out_cout);
                        if (exp_q.size() == 0) begin
                            chk($sformatf("i%0d unexpected output", gi), 64'd1, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("i%0d sum", gi), 64'(out_sum), 64'(e.sum));
                            chk($sformatf("i%0d cout", gi), 64'(out_cout), 64'(e.cout));
                            chk($sformatf("i%0d gf", gi), 64'(out_gf), 64'(e.gf));
                            chk($sformatf("i%0d latency", gi), 64'(cyc - e.acc_cyc),
                                64'(S + stalls - e.acc_stall));
                            if (e.lit) begin
                                chk($sformatf("i%0d literal sum", gi), 64'(out_sum), 64'(e.lit_sum));
                                chk($sformatf("i%0d literal cout", gi), 64'(out_cout), 64'(e.lit_cout));
                            end
                        end
                    end
                    if (drv_valid[gi] && in_ready) begin
                        ma = {32'd0, drv_a[gi]} & MASK;
                        mb = {32'd0, drv_b[gi]} & MASK;
                        if (drv_gf[gi]) begin
                            e.sum  = 32'(ma ^ mb);
                            e.cout = 1'b0;
                        end else begin
                            full   = ma + mb + {63'd0, drv_cin[gi]};
                            e.sum  = 32'(full & MASK);
                            e.cout = full[W];
                        end
                        e.gf        = drv_gf[gi];
                        e.lit       = drv_lit[gi];
                        e.lit_sum   = drv_lit_sum[gi];
                        e.lit_cout  = drv_lit_cout[gi];
                        e.acc_cyc   = cyc;
                        e.acc_stall = stalls;
                        exp_q.push_back(e);
                    end
                    hold_v    = out_valid && !drv_ordy[gi];
                    hold_sum  = out_sum;
                    hold_cout = out_cout;
                    hold_gf   = out_gf;
                    if (!in_ready) stalls++;
                end
                cyc++;
                pend[gi] = exp_q.size();
            end
        end
    endgenerate

    // Presents one operand pair and holds it until the DUT accepts it.
    // Called and returns at 1 time unit after a rising edge.
    task automatic send(input int i, input logic gf, input logic cin,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic lit, input logic [31:0] lsum, input logic lcout);
        int n = 0;
        drv_valid[i]    = 1'b1;
        drv_gf[i]       = gf;
        drv_cin[i]      = cin;
        drv_a[i]        = a;
        drv_b[i]        = b;
        drv_lit[i]      = lit;
        drv_lit_sum[i]  = lsum;
        drv_lit_cout[i] = lcout;
        @(negedge clk);
        while (!dut_irdy[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk($sformatf("i%0d send timeout", i), 64'd1, 64'd0);
        @(posedge clk);
        #1;
        drv_valid[i] = 1'b0;
        drv_lit[i]   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        drv_valid    = '0;
        drv_gf       = '0;
        drv_cin      = '0;
        drv_lit      = '0;
        drv_lit_cout = '0;
        drv_ordy     = '1;
        rand_done    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv_a[i]       = '0;
            drv_b[i]       = '0;
            drv_lit_sum[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // 32-bit / 4 stages: directed vectors
        send(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1);
        idle(6);
        send(0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE, 1'b0);
        idle(6);
        send(0, 1'b0, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 32'h2143_6587, 1'b0);
        send(0, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'hFFFF_FFFF, 1'b0);
        send(0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1);
        send(0, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0000, 1'b0);
        send(0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0);
        send(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        idle(6);

        // Backpressure: stall the output while five transactions are queued
        drv_ordy[0] = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(0, k[0], 1'b1, 32'h1111_1111 * (k + 1), 32'hF000_000F + k,
                         1'b0, 32'd0, 1'b0);
            end
            begin
                idle(8);
                drv_ordy[0] = 1'b1;
            end
        join
        idle(8);

        // Reset with three transactions in flight
        for (int k = 0; k < 3; k++)
            send(0, 1'b0, 1'b0, 32'hDEAD_0000 + k, 32'h0000_BEEF, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(8);

        // 8-bit / 1 stage
        send(1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1);
        send(1, 1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0);
        send(1, 1'b0, 1'b1, 32'h0000_007F, 32'h0000_0080, 1'b1, 32'h0000_0000, 1'b1);
        idle(4);

        // 16-bit / 16 stages: random binary with free output, then random
        // GF with random output backpressure
        for (int k = 0; k < 1000; k++)
            send(2, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, 32'd0, 1'b0);
        fork
            begin
                for (int k = 0; k < 1000; k++)
                    send(2, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, 32'd0, 1'b0);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    drv_ordy[2] = 1'($urandom_range(0, 3) != 0);
                end
                drv_ordy[2] = 1'b1;
            end
        join
        idle(40);

        for (int i = 0; i < 3; i++)
            chk($sformatf("i%0d results outstanding", i), 64'(pend[i]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
